keypad_scanner: RTL and testbench

Input-side counterpart to the seven-segment display driver. It drives active-low one-hot column strobes across a 4x4 matrix keypad and reads the active-low row returns. It debounces the result, decodes it to a 4-bit hex key code and shifts accepted digits into a 16-bit entry register. That register connects directly to the display's 16-bit `inputNum`.

---
 rtl/keypad_if.sv | 14 +
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix strobes/returns plus the decoded entry outputs.
// The slave side is the scanner itself; the master side is the keypad/consumer.
interface keypad_if;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        keyHeld;
  logic [15:0] number;

  modport master (output row, clear, input col, keyValid, keyCode, keyHeld, number);
  modport slave  (input row, clear, output col, keyValid, keyCode, keyHeld, number);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, per-scan accumulation, scan-level debounce,
// hex decode and a 4-digit shift-in entry register for the seven-segment display.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic     clk,
  input logic     rst_n,
  keypad_if.slave kp
);
  localparam int unsigned   DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned   CW       = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS - 1);
  localparam bit            DEB1     = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_e;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic [1:0]    acc_cnt_q;
  logic [3:0]    acc_code_q;
  state_e        state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q, held_q;
  logic [3:0]    code_q;
  logic [15:0]   number_q;

  logic          tick, eos, accept;
  logic [2:0]    col_hits, hit_sum;
  logic [3:0]    col_code;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  assign tick = (div_q == DIV_LAST);
  assign eos  = tick && (col_q == 2'd3);

  // Scan result folds in the current column's sample so the column-3 tick sees the full scan.
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code(2'(r), col_q);
      end
    end
    hit_sum   = {1'b0, acc_cnt_q} + col_hits;
    scan_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = (col_hits != 3'd0) ? col_code : acc_code_q;
    accept    = eos && (scan_cnt == 2'd1) &&
                ((state_q == S_IDLE && DEB1) ||
                 (state_q == S_DEBOUNCE && scan_code == cand_q && cnt_q == DEB_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      div_q      <= '0;
      col_q      <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      div_q      <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        col_q <= col_q + 2'd1;
        if (eos) begin
          acc_cnt_q  <= '0;
          acc_code_q <= '0;
        end else begin
          acc_cnt_q  <= scan_cnt;
          acc_code_q <= scan_code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      code_q   <= '0;
      number_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (kp.clear) number_q <= '0;
      if (accept) begin
        state_q <= S_PRESSED;
        code_q  <= scan_code;
        valid_q <= 1'b1;
        held_q  <= 1'b1;
        if (!kp.clear) number_q <= {number_q[11:0], scan_code};
      end else if (eos) begin
        case (state_q)
          S_IDLE: if (scan_cnt == 2'd1) begin
            state_q <= S_DEBOUNCE;
            cand_q  <= scan_code;
            cnt_q   <= CW'(1);
          end
          S_DEBOUNCE: begin
            if (scan_cnt != 2'd1) begin
              state_q <= S_IDLE;
            end else if (scan_code == cand_q) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              cand_q <= scan_code;
              cnt_q  <= CW'(1);
            end
          end
          S_PRESSED: if (scan_cnt == 2'd0) begin
            if (DEB1) begin
              state_q <= S_IDLE;
              held_q  <= 1'b0;
            end else begin
              state_q <= S_RELEASE;
              cnt_q   <= CW'(1);
            end
          end
          S_RELEASE: begin
            if (scan_cnt != 2'd0) begin
              state_q <= S_PRESSED;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= S_IDLE;
              held_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign kp.col      = ~(4'b1000 >> col_q);
  assign kp.keyValid = valid_q;
  assign kp.keyCode  = code_q;
  assign kp.keyHeld  = held_q;
  assign kp.number   = number_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model feeds directed and random per-scan key sets;
// a scan-level reference (run lengths of identical scan results) predicts every output.
module tb_keypad_scanner;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned SCAN_CYC = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if kp();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  logic [15:0] keys = '0;
  logic        clr  = 1'b0;
  logic [3:0]  row_drv;

  // Pressed key (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row_drv = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col[3-c]) row_drv[r] = 1'b0;
  end
  assign kp.row   = row_drv;
  assign kp.clear = clr;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  bit          m_held, m_valid;
  int          m_run, m_prev;
  logic [3:0]  m_code;
  logic [15:0] m_num;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_held = 0; m_valid = 0; m_run = 0; m_prev = -1; m_code = '0; m_num = '0;
  endfunction

  // Result: -1 none, -2 multiple keys, else the key code.
  function automatic void model_scan(input logic [15:0] k, input bit c);
    int res;
    res = -1;
    if ($countones(k) > 1) res = -2;
    else for (int i = 0; i < 16; i++) if (k[i]) res = int'(keymap[i]);
    m_run  = (res == m_prev) ? m_run + 1 : 1;
    m_prev = res;
    m_valid = 0;
    if (!m_held && res >= 0 && m_run == int'(DEB)) begin
      m_valid = 1;
      m_held  = 1;
      m_code  = 4'(res);
      m_num   = {m_num[11:0], 4'(res)};
    end else if (m_held && res == -1 && m_run == int'(DEB)) begin
      m_held = 0;
    end
    if (c) m_num = '0;
  endfunction

  // Entered just after an end-of-scan edge; returns just after the next one.
  task automatic run_scan(input logic [15:0] k, input bit c);
    int pulses;
    pulses = 0;
    keys = k;
    repeat (SCAN_CYC - 1) begin
      @(posedge clk); #1;
      if (kp.keyValid) pulses++;
    end
    clr = c;
    @(posedge clk); #1;
    clr = 1'b0;
    model_scan(k, c);
    chk("midscan_valid", 32'(pulses), 32'd0);
    chk("keyValid", 32'(kp.keyValid), 32'(m_valid));
    chk("keyCode",  32'(kp.keyCode),  32'(m_code));
    chk("keyHeld",  32'(kp.keyHeld),  32'(m_held));
    chk("number",   32'(kp.number),   32'(m_num));
  endtask

  task automatic press(input int idx, input int hold, input int rel);
    repeat (hold) run_scan(16'(1) << idx, 1'b0);
    repeat (rel)  run_scan('0, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    int sel, a, b, len;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col",   32'(kp.col),      32'h7);
    chk("rst_valid", 32'(kp.keyValid), 32'd0);
    chk("rst_code",  32'(kp.keyCode),  32'd0);
    chk("rst_held",  32'(kp.keyHeld),  32'd0);
    chk("rst_num",   32'(kp.number),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    press(5, 6, 3);
    chk("single_num", 32'(kp.number), 32'h0005);

    press(0, 3, 3); press(1, 3, 3); press(2, 3, 3); press(3, 3, 3); press(4, 3, 3);
    chk("entry_num", 32'(kp.number), 32'h23A4);

    run_scan(16'(1) << 10, 1'b0); run_scan('0, 1'b0);
    run_scan(16'(1) << 10, 1'b0); run_scan('0, 1'b0); run_scan('0, 1'b0);
    chk("bounce_num", 32'(kp.number), 32'h23A4);

    repeat (4) run_scan(16'h0003, 1'b0);
    run_scan(16'h0001, 1'b0);
    run_scan(16'h0001, 1'b0);
    chk("rollover_valid", 32'(kp.keyValid), 32'd1);
    chk("rollover_code",  32'(kp.keyCode),  32'h1);
    press(0, 1, 3);

    press(0, 3, 3); press(1, 3, 3); press(2, 3, 3); press(4, 3, 3);
    chk("pre_clear_num", 32'(kp.number), 32'h1234);
    run_scan(16'(1) << 14, 1'b0);
    run_scan(16'(1) << 14, 1'b1);
    chk("clr_num",   32'(kp.number),   32'h0000);
    chk("clr_valid", 32'(kp.keyValid), 32'd1);
    chk("clr_code",  32'(kp.keyCode),  32'hF);
    press(14, 0, 3);

    repeat (25) begin
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      if (sel < 3) pat = '0;
      else if (sel < 9) pat = 16'(1) << a;
      else begin
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        pat = (16'(1) << a) | (16'(1) << b);
      end
      len = $urandom_range(1, 4);
      repeat (len) run_scan(pat, $urandom_range(0, 7) == 0);
    end
    press(6, 3, 0);

    keys = 16'(1) << 5;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_col", 32'(kp.col), 32'hD);
    rst_n = 1'b0;
    #1;
    chk("arst_col",   32'(kp.col),      32'h7);
    chk("arst_num",   32'(kp.number),   32'd0);
    chk("arst_valid", 32'(kp.keyValid), 32'd0);
    chk("arst_held",  32'(kp.keyHeld),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("restart_col", 32'(kp.col), 32'h7);
    press(5, 3, 3);
    chk("restart_num", 32'(kp.number), 32'h0005);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
